ip_2_mac: RTL and testbench

IPv4-to-MAC address resolution cache (ARP table) for the TOE stack. The ARP receive path writes {IP, MAC} bindings into a small fully-associative table, and the transmit path looks up the destination MAC of an outgoing IPv4 packet by IP. Lookup results are registered, with one clock of latency.

---
 rtl/ip_2_mac.sv | 104 ++++++++++
 tb/tb_ip_2_mac.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ip_2_mac.sv
// IPv4-to-MAC resolution cache: small fully-associative table with registered lookup.
// Writes update a matching slot, else fill the lowest free slot, else replace round-robin.
module ip_2_mac #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip,
  output logic [47:0] mac_o,
  output logic        found,
  input  logic [31:0] ip_i,
  input  logic [47:0] mac_i,
  input  logic        wea
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [31:0]        ip_q  [ENTRIES];
  logic [47:0]        mac_q [ENTRIES];
  logic [IdxW-1:0]    rp_q;

  logic            hit;
  logic [47:0]     hit_mac;
  logic            wr_match;
  logic [IdxW-1:0] wr_match_idx;
  logic            wr_free;
  logic [IdxW-1:0] wr_free_idx;
  logic            wr_en;
  logic            wr_replace;
  logic [IdxW-1:0] wr_idx;

  // Valid IPs are unique, so OR-reducing the hit MACs yields the single match.
  always_comb begin
    hit     = 1'b0;
    hit_mac = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (ip_q[i] == ip) && (ip != 32'd0)) begin
        hit     = 1'b1;
        hit_mac = hit_mac | mac_q[i];
      end
    end
  end

  always_comb begin
    wr_match     = 1'b0;
    wr_match_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (ip_q[i] == ip_i)) begin
        wr_match     = 1'b1;
        wr_match_idx = IdxW'(i);
      end
    end
  end

  // Scan downwards so the last assignment wins with the lowest free index.
  always_comb begin
    wr_free     = 1'b0;
    wr_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        wr_free     = 1'b1;
        wr_free_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    wr_en      = wea && (ip_i != 32'd0);
    wr_replace = wr_en && !wr_match && !wr_free;
    if (wr_match) begin
      wr_idx = wr_match_idx;
    end else if (wr_free) begin
      wr_idx = wr_free_idx;
    end else begin
      wr_idx = rp_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      found   <= 1'b0;
      mac_o   <= '0;
      valid_q <= '0;
      rp_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
      end
    end else begin
      found <= hit;
      mac_o <= hit_mac;
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        ip_q[wr_idx]    <= ip_i;
        mac_q[wr_idx]   <= mac_i;
      end
      if (wr_replace) begin
        rp_q <= rp_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ip_2_mac.sv
// Bench for ip_2_mac: directed scenarios with literal expectations, then random traffic
// checked every cycle against a slot-level table model.
module tb_ip_2_mac;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ip = '0;
  logic [31:0] ip_i = '0;
  logic [47:0] mac_i = '0;
  logic        wea = 1'b0;
  logic [47:0] mac_o;
  logic        found;

  ip_2_mac #(.ENTRIES(N)) dut (
    .clk  (clk),
    .reset(reset),
    .ip   (ip),
    .mac_o(mac_o),
    .found(found),
    .ip_i (ip_i),
    .mac_i(mac_i),
    .wea  (wea)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_valid [N];
  logic [31:0] m_ip    [N];
  logic [47:0] m_mac   [N];
  int          m_rp = 0;

  logic        exp_found = 1'b0;
  logic [47:0] exp_mac = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_rp = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] a, output logic f,
                                       output logic [47:0] m);
    f = 1'b0;
    m = '0;
    if (a != 32'd0) begin
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && m_ip[i] == a) begin
          f = 1'b1;
          m = m_mac[i];
        end
      end
    end
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [47:0] m);
    if (a == 32'd0) return;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_ip[i] == a) begin
        m_mac[i] = m;
        return;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!m_valid[i]) begin
        m_valid[i] = 1'b1;
        m_ip[i]    = a;
        m_mac[i]   = m;
        return;
      end
    end
    m_ip[m_rp]  = a;
    m_mac[m_rp] = m;
    m_rp        = (m_rp + 1) % N;
  endfunction

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  // Continuous compare: outputs are stable between edges, sampled on the falling edge.
  always @(negedge clk) begin
    check("found", {63'd0, found}, {63'd0, exp_found});
    check("mac_o", {16'd0, mac_o}, {16'd0, exp_mac});
  end

  // One clock: drive on the falling edge, advance the model on the rising edge.
  task automatic cycle(input logic [31:0] lip, input bit w, input logic [31:0] wip,
                       input logic [47:0] wmac);
    @(negedge clk);
    ip    = lip;
    wea   = w;
    ip_i  = wip;
    mac_i = wmac;
    @(posedge clk);
    model_lookup(lip, exp_found, exp_mac);
    if (w) model_write(wip, wmac);
  endtask

  task automatic lit(input string name, input logic f, input logic [47:0] m);
    #1;
    check({name, "_found"}, {63'd0, found}, {63'd0, f});
    check({name, "_mac"}, {16'd0, mac_o}, {16'd0, m});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    wea = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_reset_found", {63'd0, found}, 64'd0);
    check("async_reset_mac", {16'd0, mac_o}, 64'd0);
    model_clear();
    exp_found = 1'b0;
    exp_mac   = '0;
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] a;
    logic [31:0] b;
    model_clear();
    #22 reset = 1'b1;

    // Reset then lookup
    cycle(32'h0AD680EA, 1'b0, '0, '0);
    lit("reset_lookup", 1'b0, 48'h0);

    // Write then lookup, with a second write in the lookup cycle
    cycle(32'h0, 1'b1, 32'h0AD680EA, 48'h9CEBE822FD18);
    cycle(32'h0AD680EA, 1'b1, 32'h0BD680EA, 48'h9CEBE822FD19);
    lit("wr_lookup_a", 1'b1, 48'h9CEBE822FD18);
    cycle(32'h0BD680EA, 1'b0, '0, '0);
    lit("wr_lookup_b", 1'b1, 48'h9CEBE822FD19);

    // Same-cycle collision sees the old table, then update in place
    pulse_reset();
    cycle(32'h0A000001, 1'b1, 32'h0A000001, 48'h111111111111);
    lit("collide", 1'b0, 48'h0);
    cycle(32'h0A000001, 1'b0, '0, '0);
    lit("collide_next", 1'b1, 48'h111111111111);
    cycle(32'h0, 1'b1, 32'h0A000001, 48'h222222222222);
    cycle(32'h0A000001, 1'b0, '0, '0);
    lit("rewrite", 1'b1, 48'h222222222222);
    check("rewrite_occupancy", 64'(occupancy()), 64'd1);

    // Full-table replacement
    for (int k = 1; k <= 9; k++) cycle(32'h0, 1'b1, 32'h0A000000 + k, 48'hAA0000000000 + k);
    cycle(32'h0A000001, 1'b0, '0, '0);
    lit("evict_1", 1'b0, 48'h0);
    cycle(32'h0A000009, 1'b0, '0, '0);
    lit("hit_9", 1'b1, 48'hAA0000000009);
    cycle(32'h0A000002, 1'b0, '0, '0);
    lit("hit_2", 1'b1, 48'hAA0000000002);
    cycle(32'h0, 1'b1, 32'h0A00000A, 48'hAA000000000A);
    cycle(32'h0A000002, 1'b0, '0, '0);
    lit("evict_2", 1'b0, 48'h0);
    cycle(32'h0A00000A, 1'b0, '0, '0);
    lit("hit_10", 1'b1, 48'hAA000000000A);

    // Zero IP is never stored or matched
    pulse_reset();
    cycle(32'h0, 1'b1, 32'h0, 48'h123456789ABC);
    cycle(32'h0, 1'b0, '0, '0);
    lit("zero_ip", 1'b0, 48'h0);
    check("zero_occupancy", 64'(occupancy()), 64'd0);

    // Async reset mid-run
    for (int k = 1; k <= 3; k++) cycle(32'h0, 1'b1, 32'h0B000000 + k, 48'hBB0000000000 + k);
    cycle(32'h0B000002, 1'b0, '0, '0);
    lit("pre_reset_hit", 1'b1, 48'hBB0000000002);
    pulse_reset();
    for (int k = 1; k <= 3; k++) begin
      cycle(32'h0B000000 + k, 1'b0, '0, '0);
      lit("post_reset_miss", 1'b0, 48'h0);
    end

    // Random traffic over a small IP pool to exercise hits, updates and replacement
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 11) == 0) ? 32'h0 : 32'h0C000000 + $urandom_range(1, 12);
      b = ($urandom_range(0, 11) == 0) ? 32'h0 : 32'h0C000000 + $urandom_range(1, 12);
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else cycle(a, 1'($urandom_range(0, 1)), b, r[47:0]);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
